// File: rtl/fxp_mul.sv
// fxp_mul -- unsigned fixed-point multiplier with a one-cycle registered result.
//
// Operands and result share the format Q(TOTAL_BITS-FRACTIONAL_BITS).FRACTIONAL_BITS.
// The exact 2*TOTAL_BITS product is rescaled by FRACTIONAL_BITS. It is then
// truncated or rounded half-up, and finally wrapped or saturated back to
// TOTAL_BITS. A new operand pair can be accepted on every clock.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   in1/in2 carry a pair to sample this cycle
//   in1, in2   unsigned fixed-point operands (TOTAL_BITS wide)
//   out_valid  out/overflow hold the result of the pair sampled on the last edge
//   out        unsigned fixed-point product (TOTAL_BITS wide)
//   overflow   integer part of the product did not fit into out
module fxp_mul #(
  parameter int TOTAL_BITS      = 7,
  parameter int FRACTIONAL_BITS = 3,
  parameter int SATURATE        = 0,
  parameter int ROUND           = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [TOTAL_BITS-1:0] in1,
  input  logic [TOTAL_BITS-1:0] in2,
  output logic                  out_valid,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  overflow
);

  localparam int ProdW = 2 * TOTAL_BITS;

  logic [ProdW-1:0]      product;
  logic                  roundBit;
  logic [ProdW-1:0]      scaled;
  logic                  overflow_d;
  logic [TOTAL_BITS-1:0] result_d;

  logic                  valid_q;
  logic [TOTAL_BITS-1:0] result_q;
  logic                  overflow_q;

  // The half-LSB bit only exists when there is a fraction to discard.
  generate
    if (ROUND != 0 && FRACTIONAL_BITS > 0) begin : gRound
      assign roundBit = product[FRACTIONAL_BITS-1];
    end else begin : gNoRound
      assign roundBit = 1'b0;
    end
  endgenerate

  // Full-width product, rescale and round. ProdW bits are enough to hold the
  // rounding carry: with F >= 1 the shifted value is below 2^(ProdW-1).
  always_comb begin
    product    = ProdW'(in1) * ProdW'(in2);
    scaled     = (product >> FRACTIONAL_BITS) + ProdW'(roundBit);
    overflow_d = |scaled[ProdW-1:TOTAL_BITS];
    if (SATURATE != 0 && overflow_d) begin
      result_d = {TOTAL_BITS{1'b1}};
    end else begin
      result_d = scaled[TOTAL_BITS-1:0];
    end
  end

  // The result registers only load on a sampled pair, so out/overflow hold
  // through idle cycles. The valid flag tracks in_valid on every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out       = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fxp_mul.sv
// tb_fxp_mul -- scoreboard bench for fxp_mul (TOTAL_BITS=7, FRACTIONAL_BITS=3).
//
// Two instances share the same stimulus. dutWrap uses the default wrap and
// truncate behaviour; dutSat saturates and rounds. Each issued pair pushes its
// hand-computed expectation for both instances into a queue. A monitor pops
// and compares whenever out_valid is seen.
module tb_fxp_mul;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [6:0] in1;
  logic [6:0] in2;

  logic       wValid;
  logic [6:0] wOut;
  logic       wOvf;
  logic       sValid;
  logic [6:0] sOut;
  logic       sOvf;

  typedef struct {
    string      name;
    logic [6:0] wOut;
    logic       wOvf;
    logic [6:0] sOut;
    logic       sOvf;
  } expect_t;

  expect_t scoreboard[$];

  int checks = 0;
  int errors = 0;

  fxp_mul #(.TOTAL_BITS(7), .FRACTIONAL_BITS(3), .SATURATE(0), .ROUND(0)) dutWrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in1(in1), .in2(in2),
    .out_valid(wValid), .out(wOut), .overflow(wOvf)
  );

  fxp_mul #(.TOTAL_BITS(7), .FRACTIONAL_BITS(3), .SATURATE(1), .ROUND(1)) dutSat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in1(in1), .in2(in2),
    .out_valid(sValid), .out(sOut), .overflow(sOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [6:0] actual,
                             input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge. A valid pair pushes its
  // expectations for both the wrap/truncate and the saturate/round instance.
  task automatic applyStimulus(input string name, input logic valid,
                               input logic [6:0] a, input logic [6:0] b,
                               input logic [6:0] ew, input logic eo,
                               input logic [6:0] es, input logic eso);
    expect_t e;
    @(negedge clk);
    in_valid = valid;
    in1      = a;
    in2      = b;
    if (valid) begin
      e.name = name; e.wOut = ew; e.wOvf = eo; e.sOut = es; e.sOvf = eso;
      scoreboard.push_back(e);
    end
  endtask

  // Monitor: compare on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    expect_t e;
    if (reset_n && (wValid || sValid)) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_valid", {6'd0, wValid | sValid}, 7'd0);
      end else begin
        e = scoreboard.pop_front();
        checkOutput({e.name, "_validSat"}, {6'd0, sValid}, 7'd1);
        checkOutput({e.name, "_validWrap"}, {6'd0, wValid}, 7'd1);
        checkOutput({e.name, "_outWrap"}, wOut, e.wOut);
        checkOutput({e.name, "_ovfWrap"}, {6'd0, wOvf}, {6'd0, e.wOvf});
        checkOutput({e.name, "_outSat"}, sOut, e.sOut);
        checkOutput({e.name, "_ovfSat"}, {6'd0, sOvf}, {6'd0, e.sOvf});
      end
    end
  end

  task automatic checkIdle(input string name, input logic [6:0] ew, input logic eo,
                           input logic [6:0] es, input logic eso);
    checkOutput({name, "_validWrap"}, {6'd0, wValid}, 7'd0);
    checkOutput({name, "_validSat"}, {6'd0, sValid}, 7'd0);
    checkOutput({name, "_outWrap"}, wOut, ew);
    checkOutput({name, "_ovfWrap"}, {6'd0, wOvf}, {6'd0, eo});
    checkOutput({name, "_outSat"}, sOut, es);
    checkOutput({name, "_ovfSat"}, {6'd0, sOvf}, {6'd0, eso});
  endtask

  initial begin
    int waitCycles;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    #2;
    checkIdle("reset_state", 7'd0, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Isolated pairs with idle gaps.
    applyStimulus("normal",   1'b1, 7'b0001_100, 7'b0010_000, 7'b0011_000, 1'b0, 7'b0011_000, 1'b0);
    applyStimulus("idle",     1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
    applyStimulus("fraction", 1'b1, 7'b1111_000, 7'b0000_100, 7'b0111_100, 1'b0, 7'b0111_100, 1'b0);
    applyStimulus("idle",     1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
    applyStimulus("wrap",     1'b1, 7'b1111_000, 7'b0010_000, 7'b1110_000, 1'b1, 7'h7F, 1'b1);
    applyStimulus("idle",     1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);

    // Back-to-back stream, then one idle cycle which must hold the last value.
    applyStimulus("stream1", 1'b1, 7'b0001_100, 7'b0010_000, 7'b0011_000, 1'b0, 7'b0011_000, 1'b0);
    applyStimulus("stream2", 1'b1, 7'b1111_000, 7'b0000_100, 7'b0111_100, 1'b0, 7'b0111_100, 1'b0);
    applyStimulus("stream3", 1'b1, 7'b1111_000, 7'b0010_000, 7'b1110_000, 1'b1, 7'h7F, 1'b1);
    applyStimulus("idle",    1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    #1;
    checkIdle("hold", 7'b1110_000, 1'b1, 7'h7F, 1'b1);

    // Boundary vectors (P = product, S = P >> 3).
    applyStimulus("round_half", 1'b1, 7'b0000_001, 7'b0000_100, 7'd0,   1'b0, 7'd1,   1'b0); // P=4
    applyStimulus("round_up",   1'b1, 7'd3,   7'd4,   7'd1,   1'b0, 7'd2,   1'b0); // P=12
    applyStimulus("trunc",      1'b1, 7'd3,   7'd3,   7'd1,   1'b0, 7'd1,   1'b0); // P=9
    applyStimulus("zero",       1'b1, 7'd0,   7'h7F,  7'd0,   1'b0, 7'd0,   1'b0);
    applyStimulus("max_max",    1'b1, 7'h7F,  7'h7F,  7'h60,  1'b1, 7'h7F,  1'b1); // S=2016
    applyStimulus("max_one",    1'b1, 7'h7F,  7'd8,   7'h7F,  1'b0, 7'h7F,  1'b0); // S=127
    applyStimulus("three_five", 1'b1, 7'd24,  7'd40,  7'd120, 1'b0, 7'd120, 1'b0); // 15.0
    applyStimulus("four_four",  1'b1, 7'd32,  7'd32,  7'd0,   1'b1, 7'h7F,  1'b1); // S=128
    applyStimulus("round_ovf",  1'b1, 7'd20,  7'd51,  7'h7F,  1'b0, 7'h7F,  1'b1); // P=1020
    applyStimulus("idle",       1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);

    waitCycles = 0;
    while (scoreboard.size() != 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("drain_before_reset", 7'(scoreboard.size()), 7'd0);

    // In-flight pair is sampled, then reset lands before the monitor sees it.
    @(negedge clk);
    in_valid = 1'b1;
    in1      = 7'b1111_000;
    in2      = 7'b0010_000;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkIdle("reset_async", 7'd0, 1'b0, 7'd0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkIdle("after_release", 7'd0, 1'b0, 7'd0, 1'b0);

    applyStimulus("post_reset", 1'b1, 7'b0001_100, 7'b0010_000, 7'b0011_000, 1'b0, 7'b0011_000, 1'b0);
    applyStimulus("idle",       1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0);

    waitCycles = 0;
    while (scoreboard.size() != 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("drain_final", 7'(scoreboard.size()), 7'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
